// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time from
// instruction memory over a req/rsp handshake, and holds it for decode until
// it is committed. The next PC is chosen at commit from decode's npc_ctl.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [63:0] pc,
    output logic [31:0] inst,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [11:0] func12,
    input  logic [2:0]  npc_ctl,
    input  logic [63:0] alu_rst,
    input  logic [63:0] pc_branch,
    input  logic [63:0] mtvec,
    input  logic [63:0] mepc,
    output logic        fetch_misalign
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [63:0] pc_reg, pc_next;
    logic [31:0] inst_reg, inst_next;
    logic        inst_valid_reg, inst_valid_next;
    logic        misalign_reg, misalign_next;
    logic [63:0] npc;
    logic        commit;

    // Requests are suppressed while reset is held, even though the state
    // register already sits in S_REQ.
    assign imem_req_valid = (state_reg == S_REQ) && !rst;
    assign imem_addr      = pc_reg;
    assign inst_valid     = inst_valid_reg;
    assign pc             = pc_reg;
    assign inst           = inst_reg;
    assign fetch_misalign = misalign_reg;

    // Decode fields come from the held instruction so they stay stable in S_HOLD.
    assign opcode = inst_reg[6:0];
    assign func3  = inst_reg[14:12];
    assign func7  = inst_reg[31:25];
    assign func12 = inst_reg[31:20];

    // inst_valid_reg is only ever set in S_HOLD, so this is the commit event.
    assign commit = inst_valid_reg && inst_ready;

    // Next-PC selection; only consumed on the commit cycle.
    always_comb begin
        npc = pc_reg + 64'd4;
        case (npc_ctl)
            3'b001:  npc = alu_rst & ~64'd1;
            3'b010:  npc = pc_branch;
            3'b011:  npc = mtvec;
            3'b100:  npc = mepc;
            default: npc = pc_reg + 64'd4;
        endcase
    end

    // FSM next-state and datapath next values.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        inst_next       = inst_reg;
        inst_valid_next = inst_valid_reg;
        misalign_next   = misalign_reg;
        case (state_reg)
            S_REQ: begin
                // Any response seen here is stale (issued before a reset) and dropped.
                if (imem_req_valid && imem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    inst_next       = imem_rsp_data;
                    inst_valid_next = 1'b1;
                    state_next      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (commit) begin
                    pc_next         = npc;
                    inst_valid_next = 1'b0;
                    state_next      = S_REQ;
                    // Misaligned target is flagged but fetch still proceeds there.
                    if (npc[1]) begin
                        misalign_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next      = S_REQ;
                inst_valid_next = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_REQ;
            pc_reg         <= RESET_PC;
            inst_reg       <= NOP_INST;
            inst_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            inst_reg       <= inst_next;
            inst_valid_reg <= inst_valid_next;
            misalign_reg   <= misalign_next;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a vector table of commits, hand-written
// stall/reset sequences, and randomized fetch/commit traffic against a model.
module tb_ifu_fetch;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [11:0] func12;
    logic [2:0]  npc_ctl = 3'b000;
    logic [63:0] alu_rst = 64'h0;
    logic [63:0] pc_branch = 64'h0;
    logic [63:0] mtvec = 64'h0;
    logic [63:0] mepc = 64'h0;
    logic        fetch_misalign;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_pc  = RESET_PC;
    logic        model_mis = 1'b0;
    logic [31:0] last_inst = 32'h0000_0013;

    ifu_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .pc(pc), .inst(inst), .opcode(opcode), .func3(func3),
        .func7(func7), .func12(func12),
        .npc_ctl(npc_ctl), .alu_rst(alu_rst), .pc_branch(pc_branch),
        .mtvec(mtvec), .mepc(mepc),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctl;
        logic [63:0] target;
        logic [63:0] exp_addr;
        logic        exp_mis;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Next PC as described by the npc_ctl encoding.
    function automatic logic [63:0] ref_npc(input logic [2:0] c, input logic [63:0] cur,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] t, input logic [63:0] e);
        case (c)
            3'd1:    return {a[63:1], 1'b0};
            3'd2:    return b;
            3'd3:    return t;
            3'd4:    return e;
            default: return cur + 64'd4;
        endcase
    endfunction

    // One fetch transaction: request (with optional ready stall), response (with delay).
    task automatic do_fetch(input logic [63:0] exp_addr, input logic [31:0] data,
                            input int req_wait, input int rsp_wait);
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("imem_addr", imem_addr, exp_addr);
        for (int i = 0; i < req_wait; i++) begin
            imem_req_ready = 1'b0;
            inst_ready     = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_req_valid", {63'd0, imem_req_valid}, 64'd1);
            chk("stall_addr", imem_addr, exp_addr);
        end
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("wait_req_low", {63'd0, imem_req_valid}, 64'd0);
        for (int i = 0; i < rsp_wait; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("wait_no_inst", {63'd0, inst_valid}, 64'd0);
        end
        inst_ready     = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom();
        last_inst      = data;
        chk("inst_valid", {63'd0, inst_valid}, 64'd1);
        chk("inst", {32'd0, inst}, {32'd0, data});
        chk("pc", pc, exp_addr);
        chk("opcode", {57'd0, opcode}, {57'd0, data[6:0]});
        chk("func3", {61'd0, func3}, {61'd0, data[14:12]});
        chk("func7", {57'd0, func7}, {57'd0, data[31:25]});
        chk("func12", {52'd0, func12}, {52'd0, data[31:20]});
        $display("fetch addr=0x%016h inst=0x%08h", exp_addr, data);
    endtask

    // Hold the instruction for some cycles, then commit with the given selection.
    task automatic do_commit(input logic [2:0] ctl, input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] t, input logic [63:0] e, input int hold);
        for (int i = 0; i < hold; i++) begin
            inst_ready = 1'b0;
            npc_ctl    = 3'($urandom());
            alu_rst    = rand64();
            pc_branch  = rand64();
            mtvec      = rand64();
            mepc       = rand64();
            @(negedge clk);
            chk("hold_valid", {63'd0, inst_valid}, 64'd1);
            chk("hold_inst", {32'd0, inst}, {32'd0, last_inst});
            chk("hold_pc", pc, model_pc);
            chk("hold_no_req", {63'd0, imem_req_valid}, 64'd0);
        end
        npc_ctl   = ctl;
        alu_rst   = a;
        pc_branch = b;
        mtvec     = t;
        mepc      = e;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        npc_ctl    = 3'($urandom());
        model_pc   = ref_npc(ctl, model_pc, a, b, t, e);
        if (model_pc[1]) model_mis = 1'b1;
        chk("commit_clears_valid", {63'd0, inst_valid}, 64'd0);
        chk("misalign", {63'd0, fetch_misalign}, {63'd0, model_mis});
        $display("commit ctl=%0d next_pc=0x%016h misalign=%0d", ctl, model_pc, model_mis);
    endtask

    vec_t vecs[9];

    initial begin
        logic [63:0] a, b, t, e;
        logic [2:0]  c;

        vecs[0] = '{3'b000, 64'h0,                   64'h0000_0000_8000_0004, 1'b0};
        vecs[1] = '{3'b010, 64'h0000_0000_8000_0100, 64'h0000_0000_8000_0100, 1'b0};
        vecs[2] = '{3'b001, 64'h0000_0000_8000_0203, 64'h0000_0000_8000_0202, 1'b1};
        vecs[3] = '{3'b011, 64'h0000_0000_8000_1000, 64'h0000_0000_8000_1000, 1'b1};
        vecs[4] = '{3'b100, 64'h0000_0000_8000_0010, 64'h0000_0000_8000_0010, 1'b1};
        vecs[5] = '{3'b101, 64'h0,                   64'h0000_0000_8000_0014, 1'b1};
        vecs[6] = '{3'b111, 64'h0,                   64'h0000_0000_8000_0018, 1'b1};
        vecs[7] = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1};
        vecs[8] = '{3'b000, 64'h0,                   64'h0000_0000_0000_0000, 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_inst", {32'd0, inst}, 64'h13);
        chk("rst_opcode", {57'd0, opcode}, 64'h13);
        chk("rst_misalign", {63'd0, fetch_misalign}, 64'd0);
        rst = 1'b0;

        // Vector table: fetch at the current PC, commit, compare the next address.
        for (int i = 0; i < 9; i++) begin
            do_fetch(model_pc, (i == 0) ? 32'h0000_0093 : $urandom(), 0, 0);
            a = rand64(); b = rand64(); t = rand64(); e = rand64();
            case (vecs[i].ctl)
                3'd1: a = vecs[i].target;
                3'd2: b = vecs[i].target;
                3'd3: t = vecs[i].target;
                3'd4: e = vecs[i].target;
                default: ;
            endcase
            do_commit(vecs[i].ctl, a, b, t, e, 0);
            chk("tbl_next_addr", imem_addr, vecs[i].exp_addr);
            chk("tbl_misalign", {63'd0, fetch_misalign}, {63'd0, vecs[i].exp_mis});
        end

        // Decode stalls for three cycles in the hold state.
        do_fetch(model_pc, 32'hABCD_E0B3, 0, 0);
        do_commit(3'b000, 64'h0, 64'h0, 64'h0, 64'h0, 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 40; i++) begin
            do_fetch(model_pc, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3));
            a = rand64(); b = rand64(); t = rand64(); e = rand64();
            c = 3'($urandom_range(0, 7));
            do_commit(c, a, b, t, e, $urandom_range(0, 3));
        end

        // Reset while waiting for a response, then a stale response in S_REQ.
        @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("midrst_pc", pc, RESET_PC);
        chk("midrst_inst", {32'd0, inst}, 64'h13);
        chk("midrst_misalign", {63'd0, fetch_misalign}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("stale_dropped_valid", {63'd0, inst_valid}, 64'd0);
        chk("stale_still_req", {63'd0, imem_req_valid}, 64'd1);
        chk("stale_inst", {32'd0, inst}, 64'h13);
        model_pc  = RESET_PC;
        model_mis = 1'b0;
        do_fetch(RESET_PC, 32'h0000_0093, 0, 0);
        do_commit(3'b000, 64'h0, 64'h0, 64'h0, 64'h0, 0);
        chk("refetch_next", imem_addr, 64'h0000_0000_8000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
